hyper_tx_packer: RTL and testbench

- Source-domain stage that feeds the TX clock-domain-crossing FIFO of the HyperBus controller.
- Accepts 32-bit uDMA TX words plus a per-transfer byte offset and byte length.
- Emits 16-bit HyperBus halfwords, each with a 2-bit byte strobe and a last flag, over a valid/ready port that connects directly to the FIFO push side.
- Skips halfword slots that are entirely outside the transfer and masks partial bytes at the head and tail.

---
 rtl/hyper_tx_packer.sv | 187 ++++++++++++++++++
 tb/tb_hyper_tx_packer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_tx_packer.sv
// hyper_tx_packer
//   Source-domain stage in front of the HyperBus TX CDC FIFO. Unpacks 32-bit
//   uDMA TX words into 16-bit halfwords with a 2-bit byte strobe and a last
//   flag. Halfword slots that hold no payload bytes are skipped, and partial
//   bytes at the head and tail of the transfer are masked through the strobe.
//
// Ports
//   src_clk_i, src_rst_ni    clock, asynchronous active-low reset
//   clear_i                  synchronous abort back to IDLE
//   cfg_valid_i/cfg_ready_o  transfer descriptor handshake (ready only in IDLE)
//   cfg_offset_i             byte offset of first payload byte in first word
//   cfg_len_i                payload byte count (0 completes immediately)
//   in_data_i/in_valid_i/in_ready_o      uDMA TX word stream
//   out_data_o/out_strb_o/out_last_o/out_valid_o/out_ready_i  FIFO push side
//   busy_o                   high outside IDLE
//   done_o                   one-cycle completion pulse
module hyper_tx_packer #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             src_clk_i,
  input  logic             src_rst_ni,
  input  logic             clear_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [1:0]       cfg_offset_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic [31:0]      in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [15:0]      out_data_o,
  output logic [1:0]       out_strb_o,
  output logic             out_last_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LO,
    S_HI
  } state_e;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO = LEN_W'(2);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [LEN_W-1:0] r_rem;
  logic             r_skip;
  logic             r_hi_first;
  logic [31:0]      r_word;
  logic             r_done;

  logic             w_s0;
  logic             w_s1;
  logic [LEN_W-1:0] w_n;
  logic             w_last;
  logic             w_emit;
  logic             w_out_hs;
  logic             w_in_hs;
  logic             w_cfg_hs;
  logic             w_len_zero;

  // Byte enables for the current slot. skip only masks the low byte of the
  // very first slot; rem bounds everything else. n never exceeds rem in an
  // emitting state, so rem cannot wrap.
  always_comb begin
    w_s0   = !r_skip && (r_rem >= ONE);
    w_s1   = w_s0 ? (r_rem >= TWO) : (r_rem >= ONE);
    w_n    = LEN_W'({1'b0, w_s0}) + LEN_W'({1'b0, w_s1});
    w_last = (r_rem == w_n);
  end

  assign w_emit     = (r_state == S_LO) || (r_state == S_HI);
  assign w_out_hs   = w_emit && out_ready_i;
  assign w_in_hs    = in_valid_i && in_ready_o;
  assign w_cfg_hs   = cfg_valid_i && cfg_ready_o;
  assign w_len_zero = (cfg_len_i == '0);

  // State register
  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      r_state <= S_IDLE;
    end else if (clear_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_cfg_hs && !w_len_zero) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_in_hs) w_state_nxt = r_hi_first ? S_HI : S_LO;
      end
      S_LO: begin
        if (w_out_hs) w_state_nxt = w_last ? S_IDLE : S_HI;
      end
      S_HI: begin
        // A prefetched word lets the next LO slot follow without a bubble.
        if (w_out_hs) begin
          if (w_last)       w_state_nxt = S_IDLE;
          else if (w_in_hs) w_state_nxt = S_LO;
          else              w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_strb_o  = '0;
    out_last_o  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cfg_ready_o = 1'b1;
      end
      S_FETCH: begin
        in_ready_o = 1'b1;
      end
      S_LO: begin
        out_valid_o = 1'b1;
        out_data_o  = r_word[15:0];
        out_strb_o  = {w_s1, w_s0};
        out_last_o  = w_last;
      end
      S_HI: begin
        out_valid_o = 1'b1;
        out_data_o  = r_word[31:16];
        out_strb_o  = {w_s1, w_s0};
        out_last_o  = w_last;
        // Never pull a word past the one holding the final byte.
        in_ready_o  = out_ready_i && !w_last;
      end
      default: ;
    endcase
  end

  assign busy_o = (r_state != S_IDLE);
  assign done_o = r_done;

  // Datapath registers
  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      r_rem      <= '0;
      r_skip     <= 1'b0;
      r_hi_first <= 1'b0;
      r_word     <= '0;
      r_done     <= 1'b0;
    end else if (clear_i) begin
      r_rem      <= '0;
      r_skip     <= 1'b0;
      r_hi_first <= 1'b0;
      r_word     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (w_cfg_hs && w_len_zero) || (w_out_hs && w_last);
      if (w_cfg_hs) begin
        r_rem      <= cfg_len_i;
        r_skip     <= cfg_offset_i[0];
        r_hi_first <= cfg_offset_i[1];
      end
      if (w_in_hs) begin
        r_word     <= in_data_i;
        r_hi_first <= 1'b0;
      end
      if (w_out_hs) begin
        r_rem  <= r_rem - w_n;
        r_skip <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hyper_tx_packer.sv
module tb_hyper_tx_packer;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_offset = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      out_data;
  logic [1:0]       out_strb;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_words [16];
  logic [15:0] exp_data [$];
  logic [1:0]  exp_strb [$];
  logic        exp_last [$];

  int first_in_cyc;
  int first_out_cyc;
  int last_out_cyc;

  always #5 clk = ~clk;

  hyper_tx_packer #(.LEN_W(LEN_W)) dut (
    .src_clk_i   (clk),
    .src_rst_ni  (rst_n),
    .clear_i     (clear),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_offset_i(cfg_offset),
    .cfg_len_i   (cfg_len),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_strb_o  (out_strb),
    .out_last_o  (out_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Reference: lay the words out as a flat byte stream, mark payload bytes,
  // and emit every 16-bit slot that holds at least one payload byte.
  task automatic build_model(input int off, input int len);
    int nw;
    logic [31:0] w;
    logic v0, v1;
    exp_data.delete(); exp_strb.delete(); exp_last.delete();
    nw = (off + len + 3) / 4;
    for (int k = 0; k < 2 * nw; k++) begin
      v0 = (2 * k >= off) && (2 * k < off + len);
      v1 = (2 * k + 1 >= off) && (2 * k + 1 < off + len);
      if (v0 || v1) begin
        w = tb_words[k / 2];
        exp_data.push_back((k % 2 == 1) ? w[31:16] : w[15:0]);
        exp_strb.push_back({v1, v0});
        exp_last.push_back(1'b0);
      end
    end
    if (exp_last.size() > 0) exp_last[exp_last.size() - 1] = 1'b1;
  endtask

  task automatic fill_words();
    for (int i = 0; i < 16; i++) tb_words[i] = $urandom;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || cfg_ready !== 1'b1 ||
        done !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0 ||
        out_strb !== 2'b00 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s: ov=%b ir=%b cr=%b done=%b busy=%b data=%h strb=%b last=%b, required 0 0 1 0 0 0000 00 0",
               tag, out_valid, in_ready, cfg_ready, done, busy, out_data, out_strb, out_last);
    end
  endtask

  task automatic run_transfer(input int off, input int len, input int pin,
                              input int pout, input int stall_idx);
    int nw, widx, oidx, cyc, stall_cnt;
    logic prev_hold;
    logic [15:0] pd;
    logic [1:0] ps;
    logic pl;
    build_model(off, len);
    nw = (off + len + 3) / 4;
    widx = 0; oidx = 0; cyc = 0; stall_cnt = 0; prev_hold = 1'b0;
    pd = '0; ps = '0; pl = 1'b0;
    first_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;

    @(negedge clk);
    cfg_valid = 1'b1; cfg_offset = 2'(off); cfg_len = LEN_W'(len);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ready: got %b, required 1", cfg_ready);
    end

    while (oidx < exp_data.size() && cyc < 400) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cyc++;
      in_valid  = ($urandom_range(99) < pin);
      in_data   = (widx < 16) ? tb_words[widx] : 32'h0;
      out_ready = ($urandom_range(99) < pout);
      if (oidx == stall_idx && stall_cnt < 5) out_ready = 1'b0;
      #1;
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_strb !== ps || out_last !== pl) begin
          errors++;
          $display("FAIL hold: got v=%b %h/%b/%b, required 1 %h/%b/%b",
                   out_valid, out_data, out_strb, out_last, pd, ps, pl);
        end
      end
      if (oidx == stall_idx && stall_cnt < 5 && out_valid) begin
        stall_cnt++;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b, required 0", in_ready);
        end
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_early: got %b, required 0 (cycle %0d)", done, cyc);
      end
      if (in_valid && in_ready) begin
        if (first_in_cyc < 0) first_in_cyc = cyc;
        widx++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== exp_data[oidx] || out_strb !== exp_strb[oidx] ||
            out_last !== exp_last[oidx]) begin
          errors++;
          $display("FAIL out[%0d] off=%0d len=%0d: got %h/%b/%b, required %h/%b/%b",
                   oidx, off, len, out_data, out_strb, out_last,
                   exp_data[oidx], exp_strb[oidx], exp_last[oidx]);
        end
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        oidx++;
      end
      prev_hold = out_valid && !out_ready;
      pd = out_data; ps = out_strb; pl = out_last;
    end

    if (oidx < exp_data.size()) begin
      checks++; errors++;
      $display("FAIL timeout off=%0d len=%0d: got %0d halfwords, required %0d",
               off, len, oidx, exp_data.size());
    end

    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b ov=%b cr=%b, required 1 0 0 1",
               done, busy, out_valid, cfg_ready);
    end
    checks++;
    if (in_ready !== 1'b0 || widx != nw) begin
      errors++;
      $display("FAIL words_consumed off=%0d len=%0d: got %0d (ir=%b), required %0d (ir=0)",
               off, len, widx, in_ready, nw);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: got %b, required 0", done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_idle("after_reset");
  endtask

  task automatic test_aligned_stream();
    tb_words[0] = 32'h33221100; tb_words[1] = 32'h77665544;
    tb_words[2] = 32'hDEADBEEF; tb_words[3] = 32'hCAFEF00D;
    run_transfer(0, 8, 100, 100, -1);
    checks++;
    if (last_out_cyc - first_out_cyc != 3 || first_out_cyc - first_in_cyc != 1) begin
      errors++;
      $display("FAIL throughput: got span=%0d latency=%0d, required 3 1",
               last_out_cyc - first_out_cyc, first_out_cyc - first_in_cyc);
    end
  endtask

  task automatic test_head_tail_mask();
    tb_words[0] = 32'hDDCCBBAA; tb_words[1] = 32'h44332211; tb_words[2] = 32'h99999999;
    run_transfer(3, 2, 100, 100, -1);
    tb_words[0] = 32'h44332211; tb_words[1] = 32'h88888888;
    run_transfer(1, 1, 100, 100, -1);
    run_transfer(2, 1, 100, 100, -1);
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    cfg_valid = 1'b1; cfg_offset = 2'd1; cfg_len = '0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_cfg_ready: got %b, required 1", cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: got done=%b ir=%b ov=%b cr=%b busy=%b, required 1 0 0 1 0",
               done, in_ready, out_valid, cfg_ready, busy);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_idle("zero_len_after");
  endtask

  task automatic test_stall();
    tb_words[0] = 32'h33221100; tb_words[1] = 32'h77665544; tb_words[2] = 32'h12345678;
    run_transfer(0, 6, 100, 100, 1);
  endtask

  task automatic start_pending();
    @(negedge clk);
    cfg_valid = 1'b1; cfg_offset = 2'd0; cfg_len = LEN_W'(8);
    in_valid = 1'b0; out_ready = 1'b0; in_data = 32'hA5A5A5A5;
    @(negedge clk);
    cfg_valid = 1'b0; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pending: got ov=%b, required 1", out_valid);
    end
  endtask

  task automatic test_clear_and_reset();
    start_pending();
    @(negedge clk);
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_idle("clear_abort");

    start_pending();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check_idle("async_reset_abort");
    @(negedge clk);
    rst_n = 1'b1;

    fill_words();
    run_transfer(1, 9, 100, 100, -1);
  endtask

  task automatic test_random();
    int off, len;
    for (int t = 0; t < 25; t++) begin
      fill_words();
      off = $urandom_range(3);
      len = $urandom_range(40, 1);
      run_transfer(off, len, $urandom_range(100, 30), $urandom_range(100, 30), -1);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_stream();
    test_head_tail_mask();
    test_zero_len();
    test_stall();
    test_clear_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
